// File: rtl/ud_counter_pkg.sv
// Shared types and next-value math for the modulo-N up/down counter and its checker.
// Latency: n/a (package of types and pure functions).
// Backpressure: n/a.
//
// Contents:
//   state_e   - checker FSM state (IDLE, TRACK, FAULT)
//   eff_mod   - effective modulus, N==0 meaning 2^width
//   ud_next   - next counter value for a given count, direction and modulus
// Functions work on UD_MAXW-bit operands so any instance with WIDTH <= UD_MAXW can
// call them by casting its operands up and the result back down.
package ud_counter_pkg;

    localparam int UD_MAXW = 16;
    localparam int UD_MW1  = UD_MAXW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    // Effective modulus of the counter. Result needs one bit more than the count
    // because N==0 selects the full 2^width range.
    function automatic logic [UD_MAXW:0] eff_mod(input logic [UD_MAXW-1:0] n,
                                                 input int width);
        logic [UD_MAXW:0] one;
        one = UD_MW1'(1);
        if (n == '0) begin
            return one << width;
        end
        return {1'b0, n};
    endfunction

    // Next counter value. Out-of-range counts (c >= m) are folded back into range:
    // up goes to 0, down goes to m-1.
    function automatic logic [UD_MAXW-1:0] ud_next(input logic [UD_MAXW-1:0] c,
                                                   input logic             up,
                                                   input logic [UD_MAXW:0] m);
        logic [UD_MAXW:0]   c_ext;
        logic [UD_MAXW:0]   m_top;
        logic [UD_MAXW-1:0] one;
        c_ext = {1'b0, c};
        m_top = m - UD_MW1'(1);
        one   = UD_MAXW'(1);
        if (m <= UD_MW1'(1)) begin
            return '0;
        end
        if (up) begin
            if (c_ext >= m_top) begin
                return '0;
            end
            return c + one;
        end
        if ((c == '0) || (c_ext >= m)) begin
            return m_top[UD_MAXW-1:0];
        end
        return c - one;
    endfunction

endpackage

// File: rtl/ud_wrap_tracker.sv
// Remembers the previous sample and classifies the current one as a legal wrap.
// Latency: wrap and wrap_cnt are registered, one cycle after the sample.
// Backpressure: none; a sample is taken every cycle reset is low.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   count       - current observed count
//   up, mod_m   - direction and effective modulus in force for this sample
//   match       - current sample agreed with the checker's prediction
//   wrap        - one-cycle pulse on a legal wrap
//   wrap_cnt    - saturating count of legal wraps
module ud_wrap_tracker
    import ud_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic [WIDTH:0]   mod_m,
    input  logic             match,
    output logic             wrap,
    output logic [WRAPW-1:0] wrap_cnt
);

    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             prev_up_q,    prev_up_d;
    logic [WIDTH:0]   prev_mod_q,   prev_mod_d;
    logic             prev_vld_q,   prev_vld_d;
    logic             wrap_q,       wrap_d;
    logic [WRAPW-1:0] wrap_cnt_q,   wrap_cnt_d;

    logic             at_boundary;

    // The boundary test uses the direction and modulus that were in force when the
    // previous sample was taken, i.e. the ones that produced this transition.
    always_comb begin
        at_boundary = 1'b0;
        if (prev_up_q) begin
            at_boundary = ({1'b0, prev_count_q} >= (prev_mod_q - (WIDTH+1)'(1)));
        end else begin
            at_boundary = (prev_count_q == '0);
        end
    end

    always_comb begin
        prev_count_d = count;
        prev_up_d    = up;
        prev_mod_d   = mod_m;
        prev_vld_d   = 1'b1;
        wrap_d       = prev_vld_q && match && at_boundary;
        wrap_cnt_d   = wrap_cnt_q;
        if (wrap_d && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + WRAPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count_q <= '0;
            prev_up_q    <= 1'b0;
            prev_mod_q   <= '0;
            prev_vld_q   <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            prev_count_q <= prev_count_d;
            prev_up_q    <= prev_up_d;
            prev_mod_q   <= prev_mod_d;
            prev_vld_q   <= prev_vld_d;
            wrap_q       <= wrap_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

    assign wrap     = wrap_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule

// File: rtl/ud_counter_checker.sv
// Cycle-accurate observer of a modulo-N up/down counter: predicts, compares, counts wraps.
// Latency: all outputs registered; a bad sample shows on mismatch/fault one edge later.
// Backpressure: none; observes every cycle, never stalls the counter.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (dominates all inputs)
//   N, up       - counter modulus (0 = 2^WIDTH) and direction (1 = increment)
//   count       - observed counter value
//   expected    - prediction for the current cycle's count
//   mismatch    - one-cycle pulse on a bad sample
//   wrap        - one-cycle pulse on a legal wrap
//   wrap_cnt    - saturating count of legal wraps
//   locked      - FSM in TRACK or FAULT
//   fault       - sticky error flag, cleared only by reset
module ud_counter_checker
    import ud_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] N,
    input  logic             up,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             wrap,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic             locked,
    output logic             fault
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             mismatch_q, mismatch_d;

    logic [WIDTH:0]   mod_m;
    logic             bad_sample;

    always_comb begin
        mod_m = (WIDTH+1)'(eff_mod(UD_MAXW'(N), WIDTH));
    end

    // IDLE has no prediction yet: a freshly reset counter must read 0.
    // TRACK and FAULT compare against the registered prediction.
    always_comb begin
        bad_sample = 1'b0;
        if (state_q == IDLE) begin
            bad_sample = (count != '0);
        end else begin
            bad_sample = (count != expected_q);
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bad_sample ? FAULT : TRACK;
            TRACK:   state_d = bad_sample ? FAULT : TRACK;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Prediction always re-syncs to the observed count, so in FAULT a single bad
    // sample yields a single pulse rather than a cascade.
    always_comb begin
        expected_d = WIDTH'(ud_next(UD_MAXW'(count), up, UD_MW1'(mod_m)));
        mismatch_d = bad_sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            expected_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
        end
    end

    // FSM outputs
    always_comb begin
        locked = (state_q == TRACK) || (state_q == FAULT);
        fault  = (state_q == FAULT);
    end

    assign expected = expected_q;
    assign mismatch = mismatch_q;

    ud_wrap_tracker #(
        .WIDTH (WIDTH),
        .WRAPW (WRAPW)
    ) u_wrap_tracker (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .up       (up),
        .mod_m    (mod_m),
        .match    (!bad_sample),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt)
    );

endmodule

// File: doc/ud_counter_checker.md
# ud_counter_checker

Cycle-accurate observer for the modulo-N up/down counter. It sits on the counter's output side and consumes the same `N` and `up` controls plus the counter's `count`. Each cycle it predicts the next count, flags deviations, counts wrap-arounds and latches a sticky fault. It is used in simulation benches and as an on-chip self-check next to the counter.

## Interface
- `WIDTH`, default 4: width of `count`, `N`, `expected`.
- `WRAPW`, default 8: width of the wrap-event counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high; dominates all other inputs.
- `N` input WIDTH: modulus of the observed counter; `N=0` means 2^WIDTH.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `count` input WIDTH: observed counter value.
- `expected` output WIDTH: registered prediction for the current cycle's `count`.
- `mismatch` output 1: one-cycle pulse, registered.
- `wrap` output 1: one-cycle pulse on an observed legal wrap.
- `wrap_cnt` output WRAPW: saturating count of legal wraps.
- `locked` output 1: high in TRACK or FAULT.
- `fault` output 1: sticky error flag.

## Operation
- Reset values:
  - state = IDLE.
  - `expected`=0, `mismatch`=0, `wrap`=0, `wrap_cnt`=0, `locked`=0, `fault`=0.
- Effective modulus: M = (N==0) ? 2^WIDTH : N, computed in WIDTH+1 bits.
- Next-value function nxt(c, up, M):
  - Up, c >= M-1: 0. Otherwise c+1.
  - Down, c == 0 or c >= M: M-1. Otherwise c-1.
  - M=1: always 0.
- FSM states and transitions:
  - IDLE: first cycle with `reset` low.
    - `count`==0: go to TRACK.
    - Otherwise: pulse `mismatch`, set `fault`, go to FAULT.
  - TRACK: compare `count` against `expected`.
    - Equal: stay.
    - Differ: pulse `mismatch`, set `fault`, go to FAULT.
  - FAULT: keep predicting from the observed `count` (re-sync). `mismatch` pulses on every further bad sample; `fault` stays high until `reset`.
- Prediction update:
  - Every non-reset cycle, `expected` <= nxt(`count`, `up`, M), using the current-cycle `count`, `up` and `N`.
  - The prediction is therefore for the following cycle.
- Legal wrap:
  - Defined as: `count` matched `expected`, and the previous sample was at the boundary (up: prev >= M-1; down: prev == 0).
  - Pulses `wrap`; increments `wrap_cnt`, saturating at all-ones.
  - The previous `up`/M is stored so the classification uses the direction and modulus that produced the transition.
- Simultaneous events:
  - A mismatching wrap-shaped transition is a mismatch only; no `wrap` pulse.
  - `reset` overrides any pending mismatch.
- N change mid-run:
  - Takes effect on the next prediction.
  - With count >= new M: up wraps to 0, down goes to M-1.

## Timing
- Single-cycle pipeline.
- Bad `count` sampled at edge k: `mismatch` and `fault` high after edge k+1.
- `wrap` has the same one-cycle latency as `mismatch`.
- `expected` after edge k reflects `count`/`up`/`N` sampled at edge k.
- Reset mid-operation: all outputs return to reset values after the edge where `reset` is sampled high. The IDLE→0 check restarts on the first low cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package `ud_counter_pkg`:
  - state enum (IDLE, TRACK, FAULT).
  - function `eff_mod(N)`.
  - function `ud_next(c, up, M)`; the counter RTL also reuses it.
- One natural sub-module: `ud_wrap_tracker`, holding the previous-sample registers, wrap classification and saturating `wrap_cnt`.
- FSM and comparison stay in the top.

## Test plan
- **N=4, up=1, clean counter, 6 cycles after reset:**
  - `count` 0,1,2,3,0,1.
  - Required: one `wrap` pulse, `wrap_cnt`=1, `mismatch` never, `locked`=1 from the 2nd cycle.
- **N=3, up=0 from reset:**
  - `count` 0,2,1,0,2.
  - Required: two `wrap` pulses, `wrap_cnt`=2, no mismatch.
- **N=8, up=1, injected skip 1→3:**
  - Required: `mismatch` pulses once one cycle later, `fault`=1 and stays.
  - Next `expected`=4; a following 4 gives no further pulse.
- **N changes 8→3 while `count`=5, up=1:**
  - Required: `expected`=0; `count`=0 accepted with no mismatch.
- **N=0, up=1, count reaches 15:**
  - Required: `expected`=0, then a `wrap` pulse; `wrap_cnt` saturates at 255 after 300 wraps.
- **Reset mid-FAULT:**
  - Required: next cycle `fault`=0, `wrap_cnt`=0, `locked`=0.
  - First post-reset `count`=2 raises `mismatch` (IDLE expects 0).
